formula_nested_isqrt_fsm: RTL and testbench
===========================================

Name: formula_nested_isqrt_fsm

Overview:
- Parametrised sequential evaluator for nested or summed integer square roots over N_TERMS operands.
- Uses exactly one external isqrt unit through a valid-only request/response interface.
- Nested mode computes isqrt(x0 + isqrt(x1 + ... + isqrt(x_{N-1}))). Sum mode computes isqrt(x0) + isqrt(x1) + ... + isqrt(x_{N-1}).
- Successor to the fixed three-term formula FSMs. Adds operand capture, an input-ready handshake, runtime mode select and configurable width and depth.

Parameters:
- N_TERMS, 3: number of operands; legal range is >= 1.
- W, 32: operand and result width; must be even. The isqrt result width is W/2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- arg_vld, input, 1: operand set valid.
- arg_rdy, output, 1: block can accept an operand set.
- mode, input, 1: 0 = nested, 1 = sum. Sampled on accept.
- args, input, N_TERMS*W: x_i is at args[i*W +: W].
- res_vld, output, 1: one-cycle result strobe.
- res, output, W: result.
- isqrt_x_vld, output, 1: isqrt request strobe.
- isqrt_x, output, W: isqrt operand.
- isqrt_y_vld, input, 1: isqrt response strobe.
- isqrt_y, input, W/2: isqrt result.

Behaviour:
- Reset values: state IDLE, res_vld=0, res=0, index=0, acc=0. isqrt_x_vld=0 whenever not in ISSUE.
- The isqrt unit shares clk/rst and has at most one request outstanding. The block never issues a second request before the response arrives.
- States:
  - IDLE: arg_rdy=1. Accept occurs when arg_vld && arg_rdy. On accept: capture all args and mode into registers, set idx=N_TERMS-1, acc=0, go to ISSUE.
  - ISSUE: arg_rdy=0 and isqrt_x_vld=1 for exactly one cycle. isqrt_x is xr[idx]+acc in nested mode and xr[idx] in sum mode. Addition is truncated to W bits (wraps mod 2^W). Always go to WAIT.
  - WAIT: arg_rdy=0, isqrt_x_vld=0. On isqrt_y_vld: nested sets acc=zero-extended isqrt_y; sum sets acc=acc+isqrt_y, truncated to W bits. Then, if idx==0, go to IDLE and register the new acc into res with res_vld=1 next cycle. Otherwise decrement idx and go to ISSUE.
- isqrt_x is driven from registers only, never from live args. Its value outside ISSUE is don't-care.
- res and res_vld are registered. res_vld pulses for one cycle. res holds its value until the next result.
- Latency: with isqrt response latency L (isqrt_y_vld L cycles after isqrt_x_vld), res_vld rises N_TERMS*(L+1)+1 cycles after the accept cycle.
- arg_rdy is high in the same cycle as res_vld. A held arg_vld is accepted in that cycle, giving back-to-back operation.
- arg_vld while arg_rdy=0 is ignored; no queueing.
- isqrt_y_vld outside WAIT is ignored, with no state or acc change.
- Changes to args or mode after accept have no effect on the running computation.
- N_TERMS=1: a single request is made and res=isqrt(x0) in both modes.
- The idx counter is max(1,$clog2(N_TERMS)) bits wide.
- Reset mid-operation: immediate return to IDLE. No res_vld is generated for the aborted set and the next accept behaves as after power-up.

Test Plan:
- Nested, W=32, N=3, L=4: x2=16, x1=21, x0=31, mode=0. Required: isqrt_x sequence 16, 25, 36; res=6; res_vld exactly 16 cycles after accept.
- Sum mode, same operands x2=16, x1=25, x0=36, mode=1. Required: isqrt_x sequence 16, 25, 36; res=15.
- Back-to-back with arg_vld held high: two sets {16,21,31}/mode0 then {0,0,0}/mode1. Required: second accept in the res_vld cycle of the first; results 6 then 0; arg_rdy=0 throughout each computation.
- Operand isolation: change args and mode and pulse a spurious isqrt_y_vld in IDLE and during ISSUE after accept. Required: result unchanged (6) and no extra isqrt_x_vld.
- Wrap, W=8, N=2, nested: x1=255 (isqrt 15), x0=250. Required: 250+15 truncates to 9; isqrt_x=9; res=3.
- Reset asserted in WAIT of the second term. Required: no res_vld, arg_rdy=1 the cycle after reset deasserts, and a fresh set {16,21,31} then yields 6.

Source files
------------

// File: rtl/formula_nested_isqrt_fsm.sv
// Sequential nested/summed integer square-root evaluator over N_TERMS captured
// operands, sharing one external valid-only isqrt unit.
module formula_nested_isqrt_fsm #(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_vld,
  output logic                 arg_rdy,
  input  logic                 mode,
  input  logic [N_TERMS*W-1:0] args,
  output logic                 res_vld,
  output logic [W-1:0]         res,
  output logic                 isqrt_x_vld,
  output logic [W-1:0]         isqrt_x,
  input  logic                 isqrt_y_vld,
  input  logic [W/2-1:0]       isqrt_y
);

  localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      res_q, res_d;
  logic              res_vld_q, res_vld_d;
  logic              mode_q, mode_d;
  logic [W-1:0]      xr_q [N_TERMS];
  logic [W-1:0]      xr_d [N_TERMS];

  logic [W-1:0]      x_sel;
  logic [W-1:0]      y_ext;
  logic [W-1:0]      acc_new;

  // Operand of the current term; idx may exceed N_TERMS-1 only outside ISSUE.
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (IDX_W'(i) == idx_q) x_sel = xr_q[i];
    end
  end

  assign y_ext   = {{(W/2){1'b0}}, isqrt_y};
  assign acc_new = mode_q ? (acc_q + y_ext) : y_ext;
  assign isqrt_x = mode_q ? x_sel : (x_sel + acc_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_vld_d   = 1'b0;
    mode_d      = mode_q;
    xr_d        = xr_q;
    arg_rdy     = 1'b0;
    isqrt_x_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          for (int i = 0; i < N_TERMS; i++) xr_d[i] = args[i*W +: W];
          mode_d  = mode;
          idx_d   = IDX_LAST;
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        isqrt_x_vld = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (isqrt_y_vld) begin
          acc_d = acc_new;
          if (idx_q == '0) begin
            res_d     = acc_new;
            res_vld_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  // Captured operands carry no reset; they are only read after an accept.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    xr_q   <= xr_d;
  end

  assign res     = res_q;
  assign res_vld = res_vld_q;

endmodule

// File: tb/tb_formula_nested_isqrt_fsm.sv
// Randomized self-checking bench: two DUT instances (32-bit/3 terms, 8-bit/2 terms)
// each served by a fixed-latency isqrt responder.
module tb_formula_nested_isqrt_fsm;

  localparam int L_A = 4;
  localparam int L_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // Instance A: W=32, N_TERMS=3
  logic        arg_vld_a, arg_rdy_a, mode_a, res_vld_a, xv_a, yv_a;
  logic [95:0] args_a;
  logic [31:0] res_a, x_a;
  logic [15:0] y_a, my_a, spur_y_a;
  logic        my_vld_a, spur_a;
  logic [31:0] xq_a;
  logic [31:0] reqa [$];

  // Instance B: W=8, N_TERMS=2
  logic        arg_vld_b, arg_rdy_b, mode_b, res_vld_b, xv_b, yv_b;
  logic [15:0] args_b;
  logic [7:0]  res_b, x_b;
  logic [3:0]  y_b, my_b;
  logic        my_vld_b;
  logic [7:0]  xq_b;
  logic [7:0]  reqb [$];

  assign yv_a = my_vld_a | spur_a;
  assign y_a  = spur_a ? spur_y_a : my_a;
  assign yv_b = my_vld_b;
  assign y_b  = my_b;

  formula_nested_isqrt_fsm #(.N_TERMS(3), .W(32)) dut_a (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .arg_rdy(arg_rdy_a), .mode(mode_a),
    .args(args_a), .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(xv_a),
    .isqrt_x(x_a), .isqrt_y_vld(yv_a), .isqrt_y(y_a));

  formula_nested_isqrt_fsm #(.N_TERMS(2), .W(8)) dut_b (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .arg_rdy(arg_rdy_b), .mode(mode_b),
    .args(args_b), .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(xv_b),
    .isqrt_x(x_b), .isqrt_y_vld(yv_b), .isqrt_y(y_b));

  function automatic longint isqrt_ref(input longint x);
    longint r, t;
    r = 0;
    for (int b = 16; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic longint ref_formula(input logic [95:0] a, input logic m,
                                         input int n, input int w);
    longint mask, acc, xi;
    mask = (longint'(1) << w) - 1;
    acc  = 0;
    for (int i = n - 1; i >= 0; i--) begin
      xi = longint'(a >> (i * w)) & mask;
      if (m) acc = (acc + isqrt_ref(xi)) & mask;
      else   acc = isqrt_ref((xi + acc) & mask);
    end
    return acc;
  endfunction

  // isqrt responders: response is valid L cycles after the request cycle
  initial begin
    my_vld_a = 1'b0;
    my_a     = '0;
    forever begin
      @(negedge clk);
      if (xv_a) begin
        xq_a = x_a;
        reqa.push_back(xq_a);
        repeat (L_A) @(posedge clk);
        #1;
        my_a     = 16'(isqrt_ref(longint'(xq_a)));
        my_vld_a = 1'b1;
        @(posedge clk);
        #1 my_vld_a = 1'b0;
      end
    end
  end

  initial begin
    my_vld_b = 1'b0;
    my_b     = '0;
    forever begin
      @(negedge clk);
      if (xv_b) begin
        xq_b = x_b;
        reqb.push_back(xq_b);
        repeat (L_B) @(posedge clk);
        #1;
        my_b     = 4'(isqrt_ref(longint'(xq_b)));
        my_vld_b = 1'b1;
        @(posedge clk);
        #1 my_vld_b = 1'b0;
      end
    end
  end

  // Waits (bounded) for res_vld of instance A after an accept edge.
  task automatic wait_res_a(input bit drop_vld, output int lat, output bit got,
                            output bit rdy_bad);
    lat = 0; got = 1'b0; rdy_bad = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      lat++;
      if (drop_vld) arg_vld_a = 1'b0;
      if (res_vld_a) begin
        got = 1'b1;
        break;
      end
      if (arg_rdy_a) rdy_bad = 1'b1;
    end
  endtask

  task automatic run_a(input logic [95:0] a, input logic m, input string nm,
                       input logic [31:0] exp_res);
    int lat; bit got, rb;
    @(negedge clk);
    args_a = a; mode_a = m; arg_vld_a = 1'b1;
    checks++;
    if (arg_rdy_a !== 1'b1) begin errors++; $display("FAIL %s_rdy got %0b exp 1", nm, arg_rdy_a); end
    @(posedge clk);
    wait_res_a(1'b1, lat, got, rb);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL %s_timeout got no res_vld exp res_vld", nm); end
    checks++;
    if (res_a !== exp_res) begin errors++; $display("FAIL %s_res got %0d exp %0d", nm, res_a, exp_res); end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL %s_latency got %0d exp 16", nm, lat); end
    checks++;
    if (rb) begin errors++; $display("FAIL %s_busy_rdy got arg_rdy=1 exp 0 while busy", nm); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (arg_rdy_a !== 1'b1 || res_vld_a !== 1'b0 || res_a !== 32'd0 || xv_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got rdy=%0b vld=%0b res=%0d xv=%0b exp 1 0 0 0",
               arg_rdy_a, res_vld_a, res_a, xv_a);
    end
    checks++;
    if (arg_rdy_b !== 1'b1 || res_vld_b !== 1'b0 || res_b !== 8'd0 || xv_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got rdy=%0b vld=%0b res=%0d xv=%0b exp 1 0 0 0",
               arg_rdy_b, res_vld_b, res_b, xv_b);
    end
  endtask

  task automatic test_nested();
    reqa.delete();
    run_a({32'd16, 32'd21, 32'd31}, 1'b0, "nested", 32'd6);
    checks++;
    if (reqa.size() != 3 || reqa[0] !== 32'd16 || reqa[1] !== 32'd25 || reqa[2] !== 32'd36) begin
      errors++;
      $display("FAIL nested_seq got n=%0d exp 16,25,36", reqa.size());
    end
  endtask

  task automatic test_sum();
    reqa.delete();
    run_a({32'd16, 32'd25, 32'd36}, 1'b1, "sum", 32'd15);
    checks++;
    if (reqa.size() != 3 || reqa[0] !== 32'd16 || reqa[1] !== 32'd25 || reqa[2] !== 32'd36) begin
      errors++;
      $display("FAIL sum_seq got n=%0d exp 16,25,36", reqa.size());
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit got, rb;
    @(negedge clk);
    args_a = {32'd16, 32'd21, 32'd31}; mode_a = 1'b0; arg_vld_a = 1'b1;
    @(posedge clk);
    wait_res_a(1'b0, lat, got, rb);
    checks++;
    if (!got || res_a !== 32'd6 || lat != 16) begin
      errors++; $display("FAIL b2b_first got res=%0d lat=%0d exp 6 16", res_a, lat);
    end
    checks++;
    if (arg_rdy_a !== 1'b1 || rb) begin
      errors++; $display("FAIL b2b_rdy1 got rdy=%0b busy_rdy=%0b exp 1 0", arg_rdy_a, rb);
    end
    args_a = 96'd0; mode_a = 1'b1;
    @(posedge clk);
    wait_res_a(1'b1, lat, got, rb);
    checks++;
    if (!got || res_a !== 32'd0 || lat != 16) begin
      errors++; $display("FAIL b2b_second got res=%0d lat=%0d exp 0 16", res_a, lat);
    end
    checks++;
    if (rb) begin errors++; $display("FAIL b2b_rdy2 got arg_rdy=1 exp 0 while busy"); end
  endtask

  task automatic test_isolation();
    int lat; bit got, rb;
    reqa.delete();
    @(negedge clk);
    spur_y_a = 16'd9; spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    checks++;
    if (arg_rdy_a !== 1'b1 || xv_a !== 1'b0 || res_vld_a !== 1'b0) begin
      errors++; $display("FAIL iso_idle got rdy=%0b xv=%0b vld=%0b exp 1 0 0", arg_rdy_a, xv_a, res_vld_a);
    end
    args_a = {32'd16, 32'd21, 32'd31}; mode_a = 1'b0; arg_vld_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld_a = 1'b0;
    args_a = {$urandom, $urandom, $urandom}; mode_a = 1'b1;
    spur_y_a = 16'd7; spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    wait_res_a(1'b0, lat, got, rb);
    checks++;
    if (!got || res_a !== 32'd6 || lat + 2 != 16) begin
      errors++; $display("FAIL iso_res got res=%0d lat=%0d exp 6 16", res_a, lat + 2);
    end
    checks++;
    if (reqa.size() != 3) begin
      errors++; $display("FAIL iso_reqs got %0d exp 3", reqa.size());
    end
  endtask

  task automatic test_wrap();
    int lat; bit got;
    reqb.delete();
    lat = 0; got = 1'b0;
    @(negedge clk);
    args_b = {8'd255, 8'd250}; mode_b = 1'b0; arg_vld_b = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      arg_vld_b = 1'b0;
      if (res_vld_b) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || res_b !== 8'd3 || lat != 7) begin
      errors++; $display("FAIL wrap_res got res=%0d lat=%0d exp 3 7", res_b, lat);
    end
    checks++;
    if (reqb.size() != 2 || reqb[0] !== 8'd255 || reqb[1] !== 8'd9) begin
      errors++; $display("FAIL wrap_seq got n=%0d exp 255,9", reqb.size());
    end
  endtask

  task automatic test_reset_mid();
    int nreq; bit seen_vld;
    nreq = 0; seen_vld = 1'b0;
    @(negedge clk);
    args_a = {32'd16, 32'd21, 32'd31}; mode_a = 1'b0; arg_vld_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      arg_vld_a = 1'b0;
      if (xv_a) nreq++;
      if (nreq == 2) break;
    end
    checks++;
    if (nreq != 2) begin errors++; $display("FAIL rstmid_issue got %0d reqs exp 2", nreq); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (arg_rdy_a !== 1'b1 || res_vld_a !== 1'b0 || res_a !== 32'd0) begin
      errors++; $display("FAIL rstmid_idle got rdy=%0b vld=%0b res=%0d exp 1 0 0", arg_rdy_a, res_vld_a, res_a);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_vld_a) seen_vld = 1'b1;
    end
    checks++;
    if (seen_vld) begin errors++; $display("FAIL rstmid_novld got res_vld=1 exp 0"); end
    run_a({32'd16, 32'd21, 32'd31}, 1'b0, "rstmid_fresh", 32'd6);
  endtask

  task automatic test_random();
    logic [95:0] a;
    logic [31:0] xi;
    logic        m;
    longint      e;
    for (int it = 0; it < 20; it++) begin
      for (int t = 0; t < 3; t++) begin
        xi = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
        a[t*32 +: 32] = xi;
      end
      m = 1'($urandom_range(0, 1));
      e = ref_formula(a, m, 3, 32);
      run_a(a, m, "random", 32'(e));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    arg_vld_a = 1'b0; mode_a = 1'b0; args_a = '0; spur_a = 1'b0; spur_y_a = '0;
    arg_vld_b = 1'b0; mode_b = 1'b0; args_b = '0;
    test_reset();
    test_nested();
    test_sum();
    test_back_to_back();
    test_isolation();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
